// File: rtl/state_demux1to2_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg -- shared types for the AES state path.
//   state_t    : 128-bit state word, bit 0 is the MSB.
//   slot_st_t  : holding-slot occupancy (EMPTY / FULL).
//   SEL_A/B    : encodings of the demux channel select.
// ---------------------------------------------------------------------------
package aes_pkg;

   typedef logic [0:127] state_t;

   typedef enum logic {
      SLOT_EMPTY = 1'b0,
      SLOT_FULL  = 1'b1
   } slot_st_t;

   localparam logic SEL_A = 1'b0;
   localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/state_demux1to2_if.sv
// ---------------------------------------------------------------------------
// state_demux1to2_if -- handshake bundle of the 1-to-2 state demux.
//   Producer side : in_data, in_sel, in_valid -> ; <- in_ready
//   Channel A     : <- a_data, a_valid ; a_ready ->
//   Channel B     : <- b_data, b_valid ; b_ready ->
//   a_count/b_count and CNT_W exist only when DEMUX_CNT_EN is defined.
// Modports: slave = the demux itself, master = producer/consumer side.
// ---------------------------------------------------------------------------
interface state_demux1to2_if #(
   parameter int DATA_W = 128
`ifdef DEMUX_CNT_EN
   , parameter int CNT_W = 16
`endif
);

   logic [0:DATA_W-1] in_data;
   logic              in_sel;
   logic              in_valid;
   logic              in_ready;

   logic [0:DATA_W-1] a_data;
   logic              a_valid;
   logic              a_ready;

   logic [0:DATA_W-1] b_data;
   logic              b_valid;
   logic              b_ready;

`ifdef DEMUX_CNT_EN
   logic [CNT_W-1:0]  a_count;
   logic [CNT_W-1:0]  b_count;

   modport slave (
      input  in_data, in_sel, in_valid, a_ready, b_ready,
      output in_ready, a_data, a_valid, b_data, b_valid, a_count, b_count
   );

   modport master (
      output in_data, in_sel, in_valid, a_ready, b_ready,
      input  in_ready, a_data, a_valid, b_data, b_valid, a_count, b_count
   );
`else
   modport slave (
      input  in_data, in_sel, in_valid, a_ready, b_ready,
      output in_ready, a_data, a_valid, b_data, b_valid
   );

   modport master (
      output in_data, in_sel, in_valid, a_ready, b_ready,
      input  in_ready, a_data, a_valid, b_data, b_valid
   );
`endif

endinterface

// File: rtl/state_demux1to2_slot.sv
// ---------------------------------------------------------------------------
// demux_slot -- single-entry holding register for one demux channel.
//   clk, rst_n : clock, async active-low reset (slot -> EMPTY)
//   load       : capture ld_data this cycle
//   ld_data    : word to capture
//   ready      : downstream consumer takes the word
//   valid      : slot is FULL
//   data       : held word
//   count      : completed drains, wraps (only with DEMUX_CNT_EN)
// ---------------------------------------------------------------------------
module demux_slot
   import aes_pkg::*;
#(
   parameter int DATA_W = 128
`ifdef DEMUX_CNT_EN
   , parameter int CNT_W = 16
`endif
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic [0:DATA_W-1] ld_data,
   input  logic              ready,
   output logic              valid,
   output logic [0:DATA_W-1] data
`ifdef DEMUX_CNT_EN
   , output logic [CNT_W-1:0] count
`endif
);

   slot_st_t st, st_nxt;
   logic     drain;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) st <= SLOT_EMPTY;
      else        st <= st_nxt;
   end

   always_comb begin
      st_nxt = st;
      drain  = (st == SLOT_FULL) && ready;
      valid  = (st == SLOT_FULL);
      case (st)
         SLOT_EMPTY: if (load)           st_nxt = SLOT_FULL;
         SLOT_FULL:  if (drain && !load) st_nxt = SLOT_EMPTY;
         default:                        st_nxt = SLOT_EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    data <= '0;
      else if (load) data <= ld_data;
   end

`ifdef DEMUX_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     count <= '0;
      else if (drain) count <= count + 1'b1;
   end
`endif

endmodule

// File: rtl/state_demux1to2.sv
// ---------------------------------------------------------------------------
// state_demux1to2 -- registered 1-to-2 demux for 128-bit AES state words.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : state_demux1to2_if.slave (producer in_*, channels a_*, b_*)
// in_sel = 0 steers to channel A, 1 to channel B. Each channel owns one
// holding slot, so a stalled consumer only back-pressures its own words.
// Optional macro DEMUX_CNT_EN adds per-channel transfer counters.
// ---------------------------------------------------------------------------
module state_demux1to2
   import aes_pkg::*;
#(
   parameter int DATA_W = 128
`ifdef DEMUX_CNT_EN
   , parameter int CNT_W = 16
`endif
) (
   input  logic clk,
   input  logic rst_n,
   state_demux1to2_if.slave bus
);

   logic sel_a, sel_b;
   logic a_load, b_load;

   // Selected slot accepts when empty or draining this same cycle.
   always_comb begin
      sel_a        = (bus.in_sel == SEL_A);
      sel_b        = (bus.in_sel == SEL_B);
      bus.in_ready = sel_a ? (!bus.a_valid || bus.a_ready)
                           : (!bus.b_valid || bus.b_ready);
      a_load       = bus.in_valid && bus.in_ready && sel_a;
      b_load       = bus.in_valid && bus.in_ready && sel_b;
   end

   demux_slot #(
      .DATA_W (DATA_W)
`ifdef DEMUX_CNT_EN
      , .CNT_W (CNT_W)
`endif
   ) u_slot_a (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (a_load),
      .ld_data (bus.in_data),
      .ready   (bus.a_ready),
      .valid   (bus.a_valid),
      .data    (bus.a_data)
`ifdef DEMUX_CNT_EN
      , .count (bus.a_count)
`endif
   );

   demux_slot #(
      .DATA_W (DATA_W)
`ifdef DEMUX_CNT_EN
      , .CNT_W (CNT_W)
`endif
   ) u_slot_b (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (b_load),
      .ld_data (bus.in_data),
      .ready   (bus.b_ready),
      .valid   (bus.b_valid),
      .data    (bus.b_data)
`ifdef DEMUX_CNT_EN
      , .count (bus.b_count)
`endif
   );

endmodule
